// File: rtl/conv_mem_arbiter.sv
// Two-port arbiter (host H, convolution core C) for a single-port synchronous RAM.
// Optional core lock feature enabled by defining CONV_ARB_CORE_LOCK_EN.
module conv_mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int WAIT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_req_i,
  input  logic                  h_we_i,
  input  logic [ADDR_W-1:0]     h_addr_i,
  input  logic [DATA_W-1:0]     h_wdata_i,
  output logic                  h_gnt_o,
  output logic                  h_rvalid_o,
  output logic [DATA_W-1:0]     h_rdata_o,
  input  logic                  c_req_i,
  input  logic                  c_we_i,
  input  logic [ADDR_W-1:0]     c_addr_i,
  input  logic [DATA_W-1:0]     c_wdata_i,
`ifdef CONV_ARB_CORE_LOCK_EN
  input  logic                  c_lock_i,
`endif
  output logic                  c_gnt_o,
  output logic                  c_rvalid_o,
  output logic [DATA_W-1:0]     c_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  clr_stats_i,
  output logic [WAIT_CNT_W-1:0] h_wait_cnt_o,
  output logic [WAIT_CNT_W-1:0] c_wait_cnt_o
);

  // state    | meaning
  // ARB_IDLE | RAM unused this cycle
  // ARB_HOST | host access issued to RAM this cycle
  // ARB_CORE | core access issued to RAM this cycle
  typedef enum logic [1:0] {ARB_IDLE, ARB_HOST, ARB_CORE} arb_state_t;

  arb_state_t          state_q, state_d;
  logic                rr_core_q;
  logic                sel_we_q;
  logic [ADDR_W-1:0]   sel_addr_q;
  logic [DATA_W-1:0]   sel_wdata_q;
  logic                tag_vld_q, tag_core_q;
  logic [WAIT_CNT_W-1:0] h_wait_q, c_wait_q;
  logic                h_elig, c_elig, core_lock;

  // The owner of the current cycle is masked so a held request is not granted twice in a row.
  assign h_elig = h_req_i & (state_q != ARB_HOST);
  assign c_elig = c_req_i & (state_q != ARB_CORE);

`ifdef CONV_ARB_CORE_LOCK_EN
  assign core_lock = (state_q == ARB_CORE) & c_req_i & c_lock_i;
`else
  assign core_lock = 1'b0;
`endif

  always_comb begin
    state_d = ARB_IDLE;
    if (core_lock)
      state_d = ARB_CORE;
    else if (h_elig && c_elig)
      state_d = rr_core_q ? ARB_HOST : ARB_CORE;
    else if (h_elig)
      state_d = ARB_HOST;
    else if (c_elig)
      state_d = ARB_CORE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_core_q   <= 1'b1;
      sel_we_q    <= 1'b0;
      sel_addr_q  <= '0;
      sel_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ARB_HOST) begin
        rr_core_q   <= 1'b0;
        sel_we_q    <= h_we_i;
        sel_addr_q  <= h_addr_i;
        sel_wdata_q <= h_wdata_i;
      end else if (state_d == ARB_CORE) begin
        rr_core_q   <= 1'b1;
        sel_we_q    <= c_we_i;
        sel_addr_q  <= c_addr_i;
        sel_wdata_q <= c_wdata_i;
      end
    end
  end

  // One-deep read tag: RAM data arrives the cycle after the read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= 1'b0;
      tag_core_q <= 1'b0;
    end else begin
      tag_vld_q  <= (state_q != ARB_IDLE) & ~sel_we_q;
      tag_core_q <= (state_q == ARB_CORE);
    end
  end

  assign h_gnt_o     = (state_q == ARB_HOST);
  assign c_gnt_o     = (state_q == ARB_CORE);
  assign mem_en_o    = (state_q != ARB_IDLE);
  assign mem_we_o    = mem_en_o & sel_we_q;
  assign mem_addr_o  = mem_en_o ? sel_addr_q  : '0;
  assign mem_wdata_o = mem_en_o ? sel_wdata_q : '0;

  assign h_rvalid_o = tag_vld_q & ~tag_core_q;
  assign c_rvalid_o = tag_vld_q &  tag_core_q;
  assign h_rdata_o  = h_rvalid_o ? mem_rdata_i : '0;
  assign c_rdata_o  = c_rvalid_o ? mem_rdata_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_wait_q <= '0;
      c_wait_q <= '0;
    end else if (clr_stats_i) begin
      h_wait_q <= '0;
      c_wait_q <= '0;
    end else begin
      if (h_req_i && !h_gnt_o && (h_wait_q != '1))
        h_wait_q <= h_wait_q + WAIT_CNT_W'(1);
      if (c_req_i && !c_gnt_o && (c_wait_q != '1))
        c_wait_q <= c_wait_q + WAIT_CNT_W'(1);
    end
  end

  assign h_wait_cnt_o = h_wait_q;
  assign c_wait_cnt_o = c_wait_q;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter with a RAM model and read-data scoreboard.
module tb_conv_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h_req = 1'b0, h_we = 1'b0, c_req = 1'b0, c_we = 1'b0, clr_stats = 1'b0;
  logic [AW-1:0] h_addr = '0, c_addr = '0;
  logic [DW-1:0] h_wdata = '0, c_wdata = '0;
`ifdef CONV_ARB_CORE_LOCK_EN
  logic c_lock = 1'b0;
`endif
  logic h_gnt, h_rvalid, c_gnt, c_rvalid, mem_en, mem_we;
  logic [DW-1:0] h_rdata, c_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] h_wait, c_wait;

  logic [DW-1:0] ram [32];
  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [DW-1:0] pk_data = '0;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] hq[$];
  logic [DW-1:0] cq[$];

  always #5 clk = ~clk;

  conv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CNT_W(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
    .h_gnt_o(h_gnt), .h_rvalid_o(h_rvalid), .h_rdata_o(h_rdata),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
`ifdef CONV_ARB_CORE_LOCK_EN
    .c_lock_i(c_lock),
`endif
    .c_gnt_o(c_gnt), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .clr_stats_i(clr_stats), .h_wait_cnt_o(h_wait), .c_wait_cnt_o(c_wait)
  );

  // Synchronous single-port RAM model with a bench-side preload port.
  always @(posedge clk) begin
    if (pk_en) ram[pk_addr] <= pk_data;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    step();
    pk_en = 1'b0;
  endtask

  // Scoreboard: read data popped when a port reports rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (h_rvalid) begin
        if (hq.size() == 0) check("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
        else                check("h_rdata", h_rdata, hq.pop_front());
      end else
        check("h_rdata_idle", h_rdata, 32'd0);
      if (c_rvalid) begin
        if (cq.size() == 0) check("c_rvalid_unexpected", 32'(c_rvalid), 32'd0);
        else                check("c_rdata", c_rdata, cq.pop_front());
      end else
        check("c_rdata_idle", c_rdata, 32'd0);
    end
  end

  initial begin
    step(); step();
    check("rst_h_gnt", 32'(h_gnt), 32'd0);
    check("rst_c_gnt", 32'(c_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_h_rvalid", 32'(h_rvalid), 32'd0);

    // Reset mid-run with both requesting writes
    rst_n = 1'b1;
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd7; h_wdata = 32'hA7;
    c_req = 1'b1; c_we = 1'b1; c_addr = 5'd8; c_wdata = 32'hC8;
    repeat (5) step();
    rst_n = 1'b0; #1;
    check("midrst_h_gnt", 32'(h_gnt), 32'd0);
    check("midrst_c_gnt", 32'(c_gnt), 32'd0);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_h_wait", 32'(h_wait), 32'd0);
    check("midrst_c_wait", 32'(c_wait), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("rel_h_gnt", 32'(h_gnt), 32'd1);
    check("rel_c_gnt", 32'(c_gnt), 32'd0);
    check("rel_mem_we", 32'(mem_we), 32'd1);
    check("rel_mem_addr", 32'(mem_addr), 32'd7);
    h_req = 1'b0;
    step();
    check("rel2_c_gnt", 32'(c_gnt), 32'd1);
    check("rel2_mem_wdata", mem_wdata, 32'hC8);
    check("rel2_h_wait", 32'(h_wait), 32'd1);
    check("rel2_c_wait", 32'(c_wait), 32'd2);
    c_req = 1'b0;
    step();
    check("rel3_mem_en", 32'(mem_en), 32'd0);
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    check("clr_h_wait", 32'(h_wait), 32'd0);
    check("clr_c_wait", 32'(c_wait), 32'd0);

    // Same-cycle host read / core write to one address: grant order decides
    poke(5'd3, 32'h11);
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd3;
    c_req = 1'b1; c_we = 1'b1; c_addr = 5'd3; c_wdata = 32'h55;
    hq.push_back(32'h11);
    step();
    check("raw_h_gnt", 32'(h_gnt), 32'd1);
    check("raw_c_gnt", 32'(c_gnt), 32'd0);
    h_req = 1'b0;
    step();
    check("raw_c_gnt2", 32'(c_gnt), 32'd1);
    check("raw_mem_wdata", mem_wdata, 32'h55);
    check("raw_h_rvalid", 32'(h_rvalid), 32'd1);
    c_req = 1'b0;
    step();
    h_req = 1'b1; hq.push_back(32'h55);
    step();
    check("raw2_h_gnt", 32'(h_gnt), 32'd1);
    h_req = 1'b0;
    step();
    check("raw2_h_rvalid", 32'(h_rvalid), 32'd1);
    step();

    // Host read from idle
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    poke(5'd5, 32'hDEADBEEF);
    h_req = 1'b1; h_we = 1'b0; h_addr = 5'd5;
    hq.push_back(32'hDEADBEEF);
    step();
    check("rd_h_gnt", 32'(h_gnt), 32'd1);
    check("rd_mem_en", 32'(mem_en), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("rd_mem_addr", 32'(mem_addr), 32'd5);
    check("rd_h_wait", 32'(h_wait), 32'd1);
    h_req = 1'b0;
    step();
    check("rd_h_rvalid", 32'(h_rvalid), 32'd1);
    check("rd_c_rvalid", 32'(c_rvalid), 32'd0);
    check("rd_h_wait2", 32'(h_wait), 32'd1);
    step();
    check("rd_h_rvalid_off", 32'(h_rvalid), 32'd0);

    // Core read routes data to the core port only
    c_req = 1'b1; c_we = 1'b0; c_addr = 5'd5;
    cq.push_back(32'hDEADBEEF);
    step();
    check("crd_c_gnt", 32'(c_gnt), 32'd1);
    c_req = 1'b0;
    step();
    check("crd_c_rvalid", 32'(c_rvalid), 32'd1);
    check("crd_h_rvalid", 32'(h_rvalid), 32'd0);
    step();

    // Continuous contention alternates H,C with the RAM busy every cycle
    h_req = 1'b1; h_we = 1'b1; h_addr = 5'd10; h_wdata = 32'h1010;
    c_req = 1'b1; c_we = 1'b1; c_addr = 5'd11; c_wdata = 32'h1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("alt_h_gnt%0d", i), 32'(h_gnt), 32'((i % 2) == 0));
      check($sformatf("alt_c_gnt%0d", i), 32'(c_gnt), 32'((i % 2) == 1));
      check($sformatf("alt_mem_en%0d", i), 32'(mem_en), 32'd1);
    end
    h_req = 1'b0; c_req = 1'b0;
    step(); step();
    h_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("solo_h_gnt%0d", i), 32'(h_gnt), 32'((i % 2) == 0));
      check($sformatf("solo_mem_en%0d", i), 32'(mem_en), 32'((i % 2) == 0));
    end
    h_req = 1'b0;
    step(); step();

    // Wait counter saturation and clear priority
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    h_req = 1'b1; c_req = 1'b1;
    repeat (40) step();
    check("sat_h_wait", 32'(h_wait), 32'hF);
    check("sat_c_wait", 32'(c_wait), 32'hF);
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    check("satclr_h_wait", 32'(h_wait), 32'd0);
    check("satclr_c_wait", 32'(c_wait), 32'd0);
    h_req = 1'b0; c_req = 1'b0;
    step(); step();

`ifdef CONV_ARB_CORE_LOCK_EN
    begin
      bit seen = 1'b0;
      c_lock = 1'b1; h_req = 1'b1; c_req = 1'b1;
      for (int i = 0; i < 4 && !seen; i++) begin
        step();
        seen = c_gnt;
      end
      check("lock_first_core_gnt", 32'(c_gnt), 32'd1);
      for (int i = 0; i < 4; i++) begin
        step();
        check($sformatf("lock_c_gnt%0d", i), 32'(c_gnt), 32'd1);
        check($sformatf("lock_h_gnt%0d", i), 32'(h_gnt), 32'd0);
      end
      c_lock = 1'b0;
      step();
      check("unlock_h_gnt", 32'(h_gnt), 32'd1);
      h_req = 1'b0; c_req = 1'b0;
      step(); step();
    end
`endif

    step(); step();
    check("hq_drained", 32'(hq.size()), 32'd0);
    check("cq_drained", 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
